// File: rtl/ram_req_controller_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
//   Shared types and constants for the RAM request controller and its
//   response FIFO.
//   - state_e   : controller state (INIT sweep, RUN)
//   - RSP_DEPTH : number of response buffer entries
//   - CREDIT_W  : width that holds a credit count 0..RSP_DEPTH
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int RSP_DEPTH = 2;
    localparam int CREDIT_W  = $clog2(RSP_DEPTH + 1);

endpackage

// File: rtl/ram_req_controller_rsp_fifo2.sv
// ----------------------------------------------------------------------------
// rsp_fifo2
//   Two-entry in-order synchronous FIFO holding read responses.
//   Ports:
//     CLK, RST_N      clock, asynchronous active-low reset
//     i_push, i_wdata write one entry
//     i_pop           remove the head entry
//     o_rdata         head entry (zero after reset)
//     o_count         occupancy 0..2
//     o_full, o_empty occupancy flags
// ----------------------------------------------------------------------------
module rsp_fifo2
    import ram_ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                i_push,
    input  logic [DW-1:0]       i_wdata,
    input  logic                i_pop,
    output logic [DW-1:0]       o_rdata,
    output logic [CREDIT_W-1:0] o_count,
    output logic                o_full,
    output logic                o_empty
);

    logic [DW-1:0]       r_mem [RSP_DEPTH];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [CREDIT_W-1:0] r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full  = (r_count == CREDIT_W'(RSP_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: the storage is only two words, so it is reset along with the
    // pointers; that makes the head (and thus rsp_data) read zero after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the values of the previous cycle, whatever the statement order.
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_req_controller.sv
// ----------------------------------------------------------------------------
// ram_req_controller
//   Master side of a single-port, write-first, synchronous-read RAM.
//   After reset it writes INIT_VAL into every location, then turns a
//   valid/ready request stream into RAM cycles and returns read data on a
//   valid/ready response stream through a 2-entry buffer.
//   Ports:
//     CLK, RST_N                       clock, asynchronous active-low reset
//     req_valid/req_ready/req_we/
//     req_addr/req_wdata               request stream (we=1 write, 0 read)
//     rsp_valid/rsp_ready/rsp_data     read response stream, in order
//     init_done                        high once the sweep has completed
//     mem_we/mem_addr/mem_di/mem_do    RAM interface (mem_do one cycle late)
// ----------------------------------------------------------------------------
module ram_req_controller
    import ram_ctrl_pkg::*;
#(
    parameter int            AW       = 6,
    parameter int            DW       = 16,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          init_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_do
);

    state_e              r_state;
    logic [AW-1:0]       r_init_cnt;
    logic [AW-1:0]       r_addr_hold;
    logic                r_inflight;

    logic                w_pop;
    logic                w_acc;
    logic                w_rd_acc;
    logic                w_read_ok;
    logic [CREDIT_W-1:0] w_credit;
    logic [CREDIT_W-1:0] w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    assign init_done = (r_state == RUN);

    // Credits cover both buffered data and the read whose data arrives next
    // cycle; a pop this cycle frees a slot in time for a new read, which is
    // why rsp_ready reaches req_ready combinationally.
    assign w_pop     = rsp_valid & rsp_ready;
    assign w_credit  = w_fifo_count + CREDIT_W'(r_inflight);
    assign w_read_ok = (w_credit < CREDIT_W'(RSP_DEPTH)) | w_pop;
    assign req_ready = (r_state == RUN) & (req_we | w_read_ok);
    assign w_acc     = req_valid & req_ready;
    assign w_rd_acc  = w_acc & ~req_we;

    // NOTE: every output gets a default before the branches so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = r_addr_hold;
        mem_di   = req_wdata;
        if (r_state == INIT) begin
            mem_we   = 1'b1;
            mem_addr = r_init_cnt;
            mem_di   = INIT_VAL;
        end else if (w_acc) begin
            mem_we   = req_we;
            mem_addr = req_addr;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_addr_hold <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_addr_hold <= mem_addr;
            r_inflight  <= w_rd_acc;
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (r_init_cnt == '1) r_state <= RUN;
            end
        end
    end

    // mem_do belongs to the read accepted last cycle, so it is captured now.
    rsp_fifo2 #(
        .DW (DW)
    ) u_rsp_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_push  (r_inflight),
        .i_wdata (mem_do),
        .i_pop   (w_pop),
        .o_rdata (rsp_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rsp_valid = ~w_fifo_empty;

    // The credit rule must make a push into a full, non-draining buffer impossible.
    a_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
        !(r_inflight && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_ram_req_controller.sv
module tb_ram_req_controller;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam logic [DW-1:0] ALT_INIT = 16'hA5A5;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid, req_we, rsp_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          req_ready, rsp_valid, init_done, mem_we;
    logic [DW-1:0] rsp_data, mem_di, mem_do;
    logic [AW-1:0] mem_addr;

    logic          d1_req_ready, d1_rsp_valid, d1_init_done, d1_mem_we;
    logic [DW-1:0] d1_rsp_data, d1_mem_di, d1_mem_do;
    logic [AW-1:0] d1_mem_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ram_req_controller #(.AW(AW), .DW(DW), .INIT_VAL(16'h0000)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
    );

    // Second instance shares the request stream but sweeps a non-zero value.
    ram_req_controller #(.AW(AW), .DW(DW), .INIT_VAL(ALT_INIT)) u_dut_alt (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(d1_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(d1_rsp_data),
        .init_done(d1_init_done),
        .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_di(d1_mem_di), .mem_do(d1_mem_do)
    );

    // Single-port, write-first, registered-address RAM models.
    logic [DW-1:0] ram0 [2**AW];
    logic [DW-1:0] ram1 [2**AW];

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram0[i] = 16'hDEAD;
            ram1[i] = 16'hDEAD;
        end
    end

    always @(posedge CLK) begin
        if (mem_we) begin
            ram0[mem_addr] <= mem_di;
            mem_do         <= mem_di;
        end else begin
            mem_do <= ram0[mem_addr];
        end
    end

    always @(posedge CLK) begin
        if (d1_mem_we) begin
            ram1[d1_mem_addr] <= d1_mem_di;
            d1_mem_do         <= d1_mem_di;
        end else begin
            d1_mem_do <= ram1[d1_mem_addr];
        end
    end

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rr;
        logic          e_rdy;
        logic          e_mwe;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wr_tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    function automatic vec_t mk(input logic v, input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic rr, input logic e_rdy,
                                input logic e_mwe, input logic e_rv, input logic [DW-1:0] e_rd);
        vec_t t;
        t.v = v; t.we = we; t.addr = a; t.wdata = d; t.rr = rr;
        t.e_rdy = e_rdy; t.e_mwe = e_mwe; t.e_rv = e_rv; t.e_rd = e_rd;
        return t;
    endfunction

    // Called at posedge+1 of the first cycle after reset release.
    task automatic sweep_check(input string tag);
        drive(1'b1, 1'b1, 6'd63, 16'hFFFF);
        rsp_ready = 1'b1;
        for (int i = 0; i < 2**AW; i++) begin
            @(negedge CLK);
            check($sformatf("%s mem_we[%0d]", tag, i), 32'(mem_we), 32'd1);
            check($sformatf("%s mem_addr[%0d]", tag, i), 32'(mem_addr), 32'(i));
            check($sformatf("%s mem_di[%0d]", tag, i), 32'(mem_di), 32'h0000);
            check($sformatf("%s alt mem_di[%0d]", tag, i), 32'(d1_mem_di), 32'(ALT_INIT));
            check($sformatf("%s req_ready[%0d]", tag, i), 32'(req_ready), 32'd0);
            check($sformatf("%s init_done[%0d]", tag, i), 32'(init_done), 32'd0);
            check($sformatf("%s rsp_valid[%0d]", tag, i), 32'(rsp_valid), 32'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 6'd0, 16'h0000);
        @(negedge CLK);
        check({tag, " init_done@64"}, 32'(init_done), 32'd1);
        check({tag, " alt init_done@64"}, 32'(d1_init_done), 32'd1);
        check({tag, " req_ready@64"}, 32'(req_ready), 32'd1);
        check({tag, " mem_we@64"}, 32'(mem_we), 32'd0);
        next_cycle();
    endtask

    task automatic read_both(input logic [AW-1:0] a, input logic [DW-1:0] e0,
                             input logic [DW-1:0] e1);
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, a, 16'h0000);
        @(negedge CLK);
        check($sformatf("rd%0d req_ready", a), 32'(req_ready), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 6'd0, 16'h0000);
        next_cycle();
        @(negedge CLK);
        check($sformatf("rd%0d rsp_valid", a), 32'(rsp_valid), 32'd1);
        check($sformatf("rd%0d rsp_data", a), 32'(rsp_data), 32'(e0));
        check($sformatf("rd%0d alt rsp_valid", a), 32'(d1_rsp_valid), 32'd1);
        check($sformatf("rd%0d alt rsp_data", a), 32'(d1_rsp_data), 32'(e1));
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 16'h0000);

        // Reset values.
        #2;
        check("rst init_done", 32'(init_done), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_data", 32'(rsp_data), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd1);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst alt mem_di", 32'(d1_mem_di), 32'(ALT_INIT));

        next_cycle();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        sweep_check("sweep1");

        // Write then read the same address on the next cycle.
        wr_tbl.push_back('{6'd5,  16'hBEEF});
        wr_tbl.push_back('{6'd6,  16'h1234});
        wr_tbl.push_back('{6'd63, 16'h8001});
        rsp_ready = 1'b1;
        foreach (wr_tbl[k]) begin
            drive(1'b1, 1'b1, wr_tbl[k].addr, wr_tbl[k].data);
            @(negedge CLK);
            check($sformatf("wr%0d req_ready", k), 32'(req_ready), 32'd1);
            check($sformatf("wr%0d mem_we", k), 32'(mem_we), 32'd1);
            check($sformatf("wr%0d mem_addr", k), 32'(mem_addr), 32'(wr_tbl[k].addr));
            next_cycle();
            drive(1'b1, 1'b0, wr_tbl[k].addr, 16'h0000);
            @(negedge CLK);
            check($sformatf("wr%0d rd req_ready", k), 32'(req_ready), 32'd1);
            check($sformatf("wr%0d rd mem_we", k), 32'(mem_we), 32'd0);
            next_cycle();
            drive(1'b0, 1'b0, 6'd0, 16'h0000);
            @(negedge CLK);
            check($sformatf("wr%0d rsp_valid@t+1", k), 32'(rsp_valid), 32'd0);
            check($sformatf("wr%0d mem_addr hold", k), 32'(mem_addr), 32'(wr_tbl[k].addr));
            next_cycle();
            @(negedge CLK);
            check($sformatf("wr%0d rsp_valid@t+2", k), 32'(rsp_valid), 32'd1);
            check($sformatf("wr%0d rsp_data", k), 32'(rsp_data), 32'(wr_tbl[k].data));
            next_cycle();
            @(negedge CLK);
            check($sformatf("wr%0d rsp_valid@t+3", k), 32'(rsp_valid), 32'd0);
            next_cycle();
        end

        // Preload addresses 0..7 with i*3.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(i * 3));
            next_cycle();
        end
        drive(1'b0, 1'b0, 6'd0, 16'h0000);
        next_cycle();

        // Back-to-back reads 0..7 with rsp_ready held high.
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(1, 0, AW'(j), 0, 1, 1, 0, (j >= 2), DW'((j - 2) * 3)));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 16'd18));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 16'd21));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 16'd0));
        // Back-pressure: two reads fill the credits, a write still passes.
        tbl.push_back(mk(1, 0, 6'd1,  0,        0, 1, 0, 0, 16'd0));
        tbl.push_back(mk(1, 0, 6'd2,  0,        0, 1, 0, 0, 16'd0));
        tbl.push_back(mk(1, 0, 6'd3,  0,        0, 0, 0, 1, 16'd3));
        tbl.push_back(mk(1, 0, 6'd3,  0,        0, 0, 0, 1, 16'd3));
        tbl.push_back(mk(1, 1, 6'd20, 16'h7777, 0, 1, 1, 1, 16'd3));
        tbl.push_back(mk(1, 0, 6'd3,  0,        1, 1, 0, 1, 16'd3));
        tbl.push_back(mk(1, 0, 6'd4,  0,        1, 1, 0, 1, 16'd6));
        tbl.push_back(mk(0, 0, 0,     0,        1, 1, 0, 1, 16'd9));
        tbl.push_back(mk(0, 0, 0,     0,        1, 1, 0, 1, 16'd12));
        tbl.push_back(mk(1, 0, 6'd20, 0,        1, 1, 0, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0,     0,        1, 1, 0, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0,     0,        1, 1, 0, 1, 16'h7777));
        tbl.push_back(mk(0, 0, 0,     0,        1, 1, 0, 0, 16'd0));

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].we, tbl[k].addr, tbl[k].wdata);
            rsp_ready = tbl[k].rr;
            @(negedge CLK);
            check($sformatf("vec%0d req_ready", k), 32'(req_ready), 32'(tbl[k].e_rdy));
            check($sformatf("vec%0d mem_we", k), 32'(mem_we), 32'(tbl[k].e_mwe));
            check($sformatf("vec%0d rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].e_rv));
            if (tbl[k].e_rv)
                check($sformatf("vec%0d rsp_data", k), 32'(rsp_data), 32'(tbl[k].e_rd));
            next_cycle();
        end

        // Reset with one read buffered and one in flight.
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 6'd1, 16'h0000);
        next_cycle();
        drive(1'b1, 1'b0, 6'd2, 16'h0000);
        next_cycle();
        drive(1'b0, 1'b0, 6'd0, 16'h0000);
        @(negedge CLK);
        check("mid rsp_valid before reset", 32'(rsp_valid), 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid rst rsp_data", 32'(rsp_data), 32'd0);
        check("mid rst req_ready", 32'(req_ready), 32'd0);
        check("mid rst init_done", 32'(init_done), 32'd0);
        check("mid rst mem_addr", 32'(mem_addr), 32'd0);
        rsp_ready = 1'b1;
        next_cycle();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        sweep_check("sweep2");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("no stale rsp %0d", i), 32'(rsp_valid), 32'd0);
            next_cycle();
        end

        // Sweep rewrote address 5; address 40 was never written by requests.
        read_both(6'd5,  16'h0000, ALT_INIT);
        read_both(6'd40, 16'h0000, ALT_INIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
